// File: rtl/lfsr_keystream_16.sv
// Serial 16-bit Fibonacci LFSR keystream source with a valid/ready output.
// One LFSR shift per clock; after STEPS shifts the word is registered on KEY
// and held until the consumer accepts it, then generation resumes from S.
module lfsr_keystream_16 #(
  parameter logic [15:0] TAPS     = 16'hB400,
  parameter logic [15:0] ZERO_SUB = 16'hACE1,
  parameter int unsigned STEPS    = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SEED_LD,
  input  logic [15:0] SEED,
  input  logic        KEY_READY,
  output logic [15:0] KEY,
  output logic        KEY_VALID,
  output logic        BUSY
);

  localparam logic [4:0] STEPS_C = 5'(STEPS);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] s;
  logic [4:0]  cnt;
  logic [15:0] s_step;
  logic [4:0]  cnt_inc;
  logic        last_step;

  assign s_step    = {s[14:0], ^(s & TAPS)};
  assign cnt_inc   = cnt + 5'd1;
  assign last_step = (cnt_inc == STEPS_C);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a seed load overrides everything, including a handshake.
  always_comb begin
    state_nxt = state;
    if (SEED_LD) begin
      state_nxt = GEN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        GEN:     if (last_step) state_nxt = HOLD;
        HOLD:    if (KEY_READY) state_nxt = GEN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // LFSR, step counter and output word; KEY only loads on the last step.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s   <= '0;
      cnt <= '0;
      KEY <= '0;
    end else if (SEED_LD) begin
      s   <= (SEED == 16'h0000) ? ZERO_SUB : SEED;
      cnt <= '0;
    end else begin
      case (state)
        GEN: begin
          s   <= s_step;
          cnt <= cnt_inc;
          if (last_step) KEY <= s_step;
        end
        HOLD: begin
          if (KEY_READY) cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    KEY_VALID = (state == HOLD);
    BUSY      = (state == GEN);
  end

endmodule

// File: tb/tb_lfsr_keystream_16.sv
// Scoreboard bench for lfsr_keystream_16: stimulus pushes expected words,
// a monitor pops and compares on every rising KEY_VALID.
module tb_lfsr_keystream_16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SEED_LD;
  logic [15:0] SEED;
  logic        KEY_READY;
  logic [15:0] KEY;
  logic        KEY_VALID;
  logic        BUSY;

  lfsr_keystream_16 #(.TAPS(16'hB400), .ZERO_SUB(16'hACE1), .STEPS(16)) dut (
    .CLK(CLK), .RST(RST), .SEED_LD(SEED_LD), .SEED(SEED),
    .KEY_READY(KEY_READY), .KEY(KEY), .KEY_VALID(KEY_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  int          cyc = 0;
  logic        prev_valid = 1'b0;
  logic        period_arm = 1'b0;
  logic        have_last  = 1'b0;
  int          last_rise  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference step rule: 16 shifts of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR.
  function automatic logic [15:0] lfsr_word(input logic [15:0] seed);
    logic [15:0] r;
    r = seed;
    for (int i = 0; i < 16; i++) r = {r[14:0], ^(r & 16'hB400)};
    return r;
  endfunction

  // Monitor: every fresh word is compared against the head of the queue.
  always @(negedge CLK) begin
    logic [15:0] e;
    if (!RST && KEY_VALID && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected no word at cycle %0d", KEY, cyc);
      end else begin
        e = exp_q.pop_front();
        check("key_word", {16'h0, KEY}, {16'h0, e});
        check("key_nonzero", {31'h0, KEY != 16'h0}, 32'd1);
      end
      if (period_arm) begin
        if (have_last) check("period", cyc - last_rise, 32'd17);
        have_last = 1'b1;
        last_rise = cyc;
      end
    end
    prev_valid = KEY_VALID;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load(input logic [15:0] seed);
    SEED    = seed;
    SEED_LD = 1'b1;
    tick(1);
    SEED_LD = 1'b0;
  endtask

  task automatic wait_q_empty(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!KEY_VALID && n < 40) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          busy_n;
    logic [15:0] w;

    RST = 1'b1; SEED_LD = 1'b0; SEED = '0; KEY_READY = 1'b0;
    #1;
    check("reset_key",   {16'h0, KEY}, 32'h0);
    check("reset_valid", {31'h0, KEY_VALID}, 32'h0);
    check("reset_busy",  {31'h0, BUSY}, 32'h0);
    tick(3);
    RST = 1'b0;

    // KEY_READY while IDLE has no effect.
    KEY_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("idle_ready", {15'h0, KEY_VALID, BUSY, KEY}, 32'h0);
    end
    KEY_READY = 1'b0;

    // Seed 1: 16 busy cycles, first word 002D, held with READY low.
    exp_q.push_back(16'h002D);
    load(16'h0001);
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (KEY_VALID) break;
      if (BUSY) busy_n++;
      KEY_READY = (i >= 3 && i <= 8);
      tick(1);
    end
    KEY_READY = 1'b0;
    check("busy_cycles", busy_n, 32'd16);
    check("valid_after_gen", {31'h0, KEY_VALID}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("hold_key", {15'h0, KEY_VALID, KEY}, {15'h0, 1'b1, 16'h002D});
    end

    // Handshake continues from current S.
    exp_q.push_back(lfsr_word(16'h002D));
    KEY_READY = 1'b1;
    tick(1);
    KEY_READY = 1'b0;
    check("valid_drop", {30'h0, KEY_VALID, BUSY}, 32'b01);
    wait_q_empty(40);

    // Seed load on the same edge as a handshake: the load wins.
    exp_q.push_back(16'h002D);
    SEED = 16'h0001; SEED_LD = 1'b1; KEY_READY = 1'b1;
    tick(1);
    SEED_LD = 1'b0; KEY_READY = 1'b0;
    wait_valid(n);
    check("load_vs_hs_latency", n, 32'd16);
    wait_q_empty(40);

    // SEED_LD held high: latency counts from the last load edge.
    exp_q.push_back(16'h002D);
    SEED = 16'h0001; SEED_LD = 1'b1;
    tick(3);
    SEED_LD = 1'b0;
    wait_valid(n);
    check("held_load_latency", n, 32'd16);
    wait_q_empty(40);

    // Asynchronous reset mid-GEN.
    load(16'h0001);
    tick(5);
    #2 RST = 1'b1;
    #1;
    check("async_rst", {15'h0, KEY_VALID, BUSY, KEY}, 32'h0);
    #1 RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("post_rst_idle", {15'h0, KEY_VALID, BUSY, KEY}, 32'h0);
    end

    // Seed 0 and seed ACE1 give the same word sequence.
    for (int run = 0; run < 2; run++) begin
      w = 16'hACE1;
      for (int i = 0; i < 8; i++) begin
        w = lfsr_word(w);
        exp_q.push_back(w);
      end
      KEY_READY = 1'b1;
      load(run == 0 ? 16'h0000 : 16'hACE1);
      wait_q_empty(8 * 17 + 40);
      KEY_READY = 1'b0;
      tick(2);
    end

    // READY tied high: 4096 words every 17 cycles from seed 1.
    w = 16'h0001;
    for (int i = 0; i < 4096; i++) begin
      w = lfsr_word(w);
      exp_q.push_back(w);
    end
    period_arm = 1'b1;
    have_last  = 1'b0;
    KEY_READY  = 1'b1;
    load(16'h0001);
    wait_q_empty(4096 * 17 + 40);
    KEY_READY  = 1'b0;
    period_arm = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
